// File: rtl/vslc_fetch_ctrl.sv
// vslc_fetch_ctrl: drives the SPI EEPROM reader and buffers the
// fetched bytes with their addresses in a small prefetch FIFO.
module vslc_fetch_ctrl #(
    parameter int SCK_DIV = 2,
    parameter int DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       jump_valid,
    input  logic [8:0] jump_addr,
    output logic       fetch_valid,
    output logic [7:0] fetch_byte,
    output logic [8:0] fetch_addr,
    input  logic       fetch_ready,
    output logic       rd_spi_clk,
    output logic       rd_goto,
    output logic [8:0] rd_address,
    output logic       rd_hold_n,
    input  logic       rd_ready,
    input  logic [7:0] rd_byte,
    output logic       busy,
    output logic       ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [7:0]    DIV_MAX  = 8'(SCK_DIV - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    typedef enum logic [1:0] {SEEK, STREAM, STALL} state_t;

    state_t        state_q, state_d;
    logic          boot_q, boot_d;
    logic [7:0]    div_q, div_d;
    logic          sck_q, sck_d;
    logic          goto_q, goto_d;
    logic          gcnt_q, gcnt_d;
    logic [8:0]    rd_addr_q, rd_addr_d;
    logic [8:0]    nxt_addr_q, nxt_addr_d;
    logic          arm_q, arm_d;
    logic          rdy_prev_q, rdy_prev_d;
    logic [7:0]    bmem_q [DEPTH];
    logic [7:0]    bmem_d [DEPTH];
    logic [8:0]    amem_q [DEPTH];
    logic [8:0]    amem_d [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    head_byte_q, head_byte_d;
    logic [8:0]    head_addr_q, head_addr_d;
    logic          valid_q, valid_d;
    logic          hold_n_q, hold_n_d;
    logic          busy_q, busy_d;
    logic          ovf_q, ovf_d;

    logic          jump;
    logic [8:0]    target;
    logic          tick;
    logic          fall;
    logic          full;
    logic          cap;
    logic          pop;
    logic          push;
    logic [AW-1:0] rd_nxt;

    // boot restart after reset behaves like a jump to address 0
    assign jump   = jump_valid | boot_q;
    assign target = boot_q ? 9'h000 : jump_addr;
    assign tick   = (state_q != STALL) && (div_q == DIV_MAX);
    assign fall   = tick && sck_q;
    assign full   = (count_q == CNT_FULL);
    assign cap    = (state_q != SEEK) && rd_ready && !rdy_prev_q && arm_q;
    assign pop    = fetch_ready && (count_q != '0);
    assign push   = cap && (!full || pop);
    assign rd_nxt = rd_ptr_q + 1'b1;

    // next-state: divider, seek handshake, capture and FIFO bookkeeping
    always_comb begin
        state_d     = state_q;
        boot_d      = boot_q;
        div_d       = div_q;
        sck_d       = sck_q;
        goto_d      = goto_q;
        gcnt_d      = gcnt_q;
        rd_addr_d   = rd_addr_q;
        nxt_addr_d  = nxt_addr_q;
        arm_d       = arm_q;
        rdy_prev_d  = rd_ready;
        bmem_d      = bmem_q;
        amem_d      = amem_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        head_byte_d = head_byte_q;
        head_addr_d = head_addr_q;
        ovf_d       = ovf_q;

        if (tick) begin
            div_d = '0;
            sck_d = ~sck_q;
        end else if (state_q != STALL) begin
            div_d = div_q + 8'd1;
        end

        if (jump) begin
            state_d    = SEEK;
            boot_d     = 1'b0;
            goto_d     = 1'b1;
            gcnt_d     = 1'b0;
            rd_addr_d  = target;
            nxt_addr_d = target;
            arm_d      = 1'b0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            case (state_q)
                SEEK: begin
                    if (fall) begin
                        if (gcnt_q) begin
                            goto_d  = 1'b0;
                            state_d = STREAM;
                            arm_d   = 1'b0;
                        end else begin
                            gcnt_d = 1'b1;
                        end
                    end
                end
                default: begin
                    if (!rd_ready) arm_d = 1'b1;
                    if (cap) arm_d = 1'b0;
                    if (cap && full && !pop) ovf_d = 1'b1;
                    if (pop) rd_ptr_d = rd_nxt;
                    if (push) begin
                        bmem_d[wr_ptr_q] = rd_byte;
                        amem_d[wr_ptr_q] = nxt_addr_q;
                        wr_ptr_d         = wr_ptr_q + 1'b1;
                        nxt_addr_d       = nxt_addr_q + 9'd1;
                    end
                    if (push && !pop) count_d = count_q + 1'b1;
                    if (pop && !push) count_d = count_q - 1'b1;
                    if (pop && count_q > 1) begin
                        head_byte_d = bmem_q[rd_nxt];
                        head_addr_d = amem_q[rd_nxt];
                    end else if (push && (count_q == '0 || pop)) begin
                        head_byte_d = rd_byte;
                        head_addr_d = nxt_addr_q;
                    end
                    if (state_q == STREAM && count_d == CNT_FULL) begin
                        state_d = STALL;
                    end else if (state_q == STALL && !full) begin
                        state_d = STREAM;
                    end
                end
            endcase
        end

        valid_d  = (count_d != '0);
        hold_n_d = (state_d != STALL);
        busy_d   = (state_d == SEEK);
    end

    // state and registered outputs; synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= STREAM;
            boot_q      <= 1'b1;
            div_q       <= '0;
            sck_q       <= 1'b0;
            goto_q      <= 1'b0;
            gcnt_q      <= 1'b0;
            rd_addr_q   <= '0;
            nxt_addr_q  <= '0;
            arm_q       <= 1'b0;
            rdy_prev_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                bmem_q[i] <= '0;
                amem_q[i] <= '0;
            end
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            head_byte_q <= '0;
            head_addr_q <= '0;
            valid_q     <= 1'b0;
            hold_n_q    <= 1'b1;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            boot_q      <= boot_d;
            div_q       <= div_d;
            sck_q       <= sck_d;
            goto_q      <= goto_d;
            gcnt_q      <= gcnt_d;
            rd_addr_q   <= rd_addr_d;
            nxt_addr_q  <= nxt_addr_d;
            arm_q       <= arm_d;
            rdy_prev_q  <= rdy_prev_d;
            bmem_q      <= bmem_d;
            amem_q      <= amem_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            head_byte_q <= head_byte_d;
            head_addr_q <= head_addr_d;
            valid_q     <= valid_d;
            hold_n_q    <= hold_n_d;
            busy_q      <= busy_d;
            ovf_q       <= ovf_d;
        end
    end

    assign fetch_valid = valid_q;
    assign fetch_byte  = head_byte_q;
    assign fetch_addr  = head_addr_q;
    assign rd_spi_clk  = sck_q;
    assign rd_goto     = goto_q;
    assign rd_address  = rd_addr_q;
    assign rd_hold_n   = hold_n_q;
    assign busy        = busy_q;
    assign ovf         = ovf_q;

endmodule

// File: tb/tb_vslc_fetch_ctrl.sv
// tb_vslc_fetch_ctrl: EEPROM reader model plus scoreboard of
// expected {addr, byte} pairs for vslc_fetch_ctrl.
module tb_vslc_fetch_ctrl;

    localparam int SCK_DIV = 2;
    localparam int DEPTH   = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       jv_t = 1'b0, jv_p = 1'b0;
    logic [8:0] ja_t = '0, ja_p = '0;
    logic       fr_t = 1'b0, fr_p = 1'b0;
    logic       rdy_m = 1'b0, frc_en = 1'b0, frc_val = 1'b0;
    logic [7:0] byte_m = '0;

    logic       jump_valid, fetch_ready, rd_ready;
    logic [8:0] jump_addr;
    logic       fetch_valid, rd_spi_clk, rd_goto, rd_hold_n, busy, ovf;
    logic [7:0] fetch_byte;
    logic [8:0] fetch_addr, rd_address;

    assign jump_valid  = jv_t | jv_p;
    assign jump_addr   = jv_p ? ja_p : ja_t;
    assign fetch_ready = fr_t | fr_p;
    assign rd_ready    = frc_en ? frc_val : rdy_m;

    vslc_fetch_ctrl #(.SCK_DIV(SCK_DIV), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .jump_valid(jump_valid), .jump_addr(jump_addr),
        .fetch_valid(fetch_valid), .fetch_byte(fetch_byte),
        .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
        .rd_spi_clk(rd_spi_clk), .rd_goto(rd_goto),
        .rd_address(rd_address), .rd_hold_n(rd_hold_n),
        .rd_ready(rd_ready), .rd_byte(byte_m),
        .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [8:0] a;
        logic [7:0] b;
    } exp_t;

    exp_t       q[$];
    int         errors = 0;
    int         checks = 0;
    int         cyc_cnt = 0;
    int         goto_rises = 0;
    int         goto_falls = 0;
    int         bitcnt = 0;
    logic [8:0] m_addr = '0;
    logic       sck_p = 1'b0, goto_p = 1'b0;
    logic       coll_arm = 1'b0, coll_hit = 1'b0;
    logic [8:0] coll_addr = '0;

    function automatic logic [7:0] mem(input logic [8:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    // reader model, collision injector and scoreboard, off the active edge
    always @(negedge clk) begin
        logic raised;
        exp_t e;
        raised = 1'b0;
        cyc_cnt++;
        jv_p = 1'b0;
        fr_p = 1'b0;
        if (rd_goto && !goto_p) begin
            goto_rises++;
            goto_falls = 0;
            m_addr = rd_address;
            bitcnt = 0;
            rdy_m = 1'b0;
        end else if (goto_p && sck_p && !rd_spi_clk) begin
            goto_falls++;
        end
        if (!rd_goto && rd_hold_n && rd_spi_clk && !sck_p) begin
            bitcnt++;
            if (bitcnt == 2) rdy_m = 1'b0;
            if (bitcnt == 8) begin
                byte_m = mem(m_addr);
                m_addr = m_addr + 9'd1;
                rdy_m = 1'b1;
                raised = 1'b1;
                bitcnt = 0;
            end
        end
        if (coll_arm && raised && fetch_valid) begin
            jv_p = 1'b1;
            ja_p = coll_addr;
            fr_p = 1'b1;
            coll_arm = 1'b0;
            coll_hit = 1'b1;
        end
        sck_p = rd_spi_clk;
        goto_p = rd_goto;
        if (rst_n && fetch_valid && (fr_t | fr_p) && !(jv_t | jv_p)) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected addr=%h byte=%h required none",
                         fetch_addr, fetch_byte);
            end else begin
                e = q.pop_front();
                if (fetch_addr !== e.a || fetch_byte !== e.b) begin
                    errors++;
                    $display("FAIL pop got %h/%h required %h/%h",
                             fetch_addr, fetch_byte, e.a, e.b);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_run(input logic [8:0] a, input int n);
        logic [8:0] x;
        for (int i = 0; i < n; i++) begin
            x = a + 9'(i);
            q.push_back('{a: x, b: mem(x)});
        end
    endtask

    task automatic consume(input int budget);
        int k;
        k = 0;
        fr_t = 1'b1;
        while (q.size() != 0 && k < budget) begin
            cyc(1);
            k++;
        end
        fr_t = 1'b0;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL consume_timeout left=%0d required 0", q.size());
        end
    endtask

    task automatic wait_stall(input int budget);
        int k;
        k = 0;
        while (rd_hold_n !== 1'b0 && k < budget) begin
            cyc(1);
            k++;
        end
        checks++;
        if (rd_hold_n !== 1'b0) begin
            errors++;
            $display("FAIL stall_timeout hold_n=%b required 0", rd_hold_n);
        end
    endtask

    int rel_cyc;

    task automatic test_reset();
        int k;
        rst_n = 1'b0;
        cyc(3);
        checks += 6;
        if (fetch_valid !== 1'b0) begin errors++;
            $display("FAIL rst_valid got %b required 0", fetch_valid); end
        if (fetch_byte !== 8'h00) begin errors++;
            $display("FAIL rst_byte got %h required 00", fetch_byte); end
        if (fetch_addr !== 9'h000) begin errors++;
            $display("FAIL rst_addr got %h required 000", fetch_addr); end
        if (ovf !== 1'b0) begin errors++;
            $display("FAIL rst_ovf got %b required 0", ovf); end
        if (rd_spi_clk !== 1'b0) begin errors++;
            $display("FAIL rst_sck got %b required 0", rd_spi_clk); end
        if (rd_hold_n !== 1'b1) begin errors++;
            $display("FAIL rst_hold_n got %b required 1", rd_hold_n); end
        rst_n = 1'b1;
        rel_cyc = cyc_cnt;
        cyc(1);
        checks += 3;
        if (busy !== 1'b1) begin errors++;
            $display("FAIL boot_busy got %b required 1", busy); end
        if (rd_goto !== 1'b1) begin errors++;
            $display("FAIL boot_goto got %b required 1", rd_goto); end
        if (rd_address !== 9'h000) begin errors++;
            $display("FAIL boot_raddr got %h required 000", rd_address); end
        k = 0;
        while (rd_goto !== 1'b0 && k < 200) begin
            cyc(1);
            k++;
        end
        cyc(1);
        checks += 2;
        if (goto_falls != 2) begin errors++;
            $display("FAIL goto_falls got %0d required 2", goto_falls); end
        if (busy !== 1'b0) begin errors++;
            $display("FAIL seek_exit_busy got %b required 0", busy); end
    endtask

    task automatic test_stream();
        int k;
        expect_run(9'h000, 3);
        k = 0;
        while (fetch_valid !== 1'b1 && k < 400) begin
            cyc(1);
            k++;
        end
        checks++;
        if (fetch_valid !== 1'b1 || cyc_cnt - rel_cyc > 40 * 2 * SCK_DIV) begin
            errors++;
            $display("FAIL first_valid cycles=%0d required <=%0d",
                     cyc_cnt - rel_cyc, 40 * 2 * SCK_DIV);
        end
        consume(400);
    endtask

    task automatic test_stall();
        logic       s0;
        logic [8:0] a0;
        wait_stall(1000);
        s0 = rd_spi_clk;
        a0 = fetch_addr;
        cyc(20);
        checks += 6;
        if (rd_hold_n !== 1'b0) begin errors++;
            $display("FAIL stall_hold_n got %b required 0", rd_hold_n); end
        if (rd_spi_clk !== s0) begin errors++;
            $display("FAIL stall_sck got %b required %b", rd_spi_clk, s0); end
        if (fetch_addr !== a0 || fetch_addr !== 9'h003) begin errors++;
            $display("FAIL stall_head got %h required 003", fetch_addr); end
        if (fetch_byte !== mem(9'h003)) begin errors++;
            $display("FAIL stall_byte got %h required %h",
                     fetch_byte, mem(9'h003)); end
        if (fetch_valid !== 1'b1 || busy !== 1'b0) begin errors++;
            $display("FAIL stall_flags got %b%b required 10",
                     fetch_valid, busy); end
        if (ovf !== 1'b0) begin errors++;
            $display("FAIL stall_ovf got %b required 0", ovf); end
        expect_run(9'h003, 6);
        consume(1000);
        checks++;
        if (ovf !== 1'b0) begin errors++;
            $display("FAIL resume_ovf got %b required 0", ovf); end
    endtask

    task automatic test_ovf();
        wait_stall(1000);
        frc_en = 1'b1;
        frc_val = 1'b0;
        cyc(2);
        frc_val = 1'b1;
        cyc(2);
        checks++;
        if (ovf !== 1'b1) begin errors++;
            $display("FAIL ovf_set got %b required 1", ovf); end
        frc_en = 1'b0;
        cyc(2);
        expect_run(9'h009, 6);
        consume(1000);
        checks++;
        if (ovf !== 1'b1) begin errors++;
            $display("FAIL ovf_sticky got %b required 1", ovf); end
    endtask

    task automatic test_jump_wrap();
        int r0;
        wait_stall(1000);
        expect_run(9'h00F, 1);
        consume(100);
        cyc(2);
        r0 = goto_rises;
        ja_t = 9'h1FE;
        jv_t = 1'b1;
        cyc(1);
        jv_t = 1'b0;
        checks += 2;
        if (fetch_valid !== 1'b0) begin errors++;
            $display("FAIL jump_flush got %b required 0", fetch_valid); end
        if (busy !== 1'b1 || rd_goto !== 1'b1 || rd_address !== 9'h1FE) begin
            errors++;
            $display("FAIL jump_seek got %b%b/%h required 11/1fe",
                     busy, rd_goto, rd_address); end
        expect_run(9'h1FE, 4);
        consume(1000);
        checks++;
        if (goto_rises - r0 != 1) begin errors++;
            $display("FAIL jump_pulses got %0d required 1", goto_rises - r0); end
    endtask

    task automatic test_jump_collide();
        int k;
        coll_addr = 9'h0A0;
        coll_hit = 1'b0;
        coll_arm = 1'b1;
        k = 0;
        while (!coll_hit && k < 1000) begin
            cyc(1);
            k++;
        end
        checks += 2;
        if (!coll_hit) begin errors++;
            coll_arm = 1'b0;
            $display("FAIL collide_timeout got 0 required 1"); end
        if (fetch_valid !== 1'b0 || busy !== 1'b1) begin errors++;
            $display("FAIL collide_flush got %b%b required 01",
                     fetch_valid, busy); end
        expect_run(9'h0A0, 3);
        consume(1000);
    endtask

    task automatic test_double_jump();
        int r0;
        r0 = goto_rises;
        ja_t = 9'h010;
        jv_t = 1'b1;
        cyc(1);
        jv_t = 1'b0;
        cyc(3 * 2 * SCK_DIV - 1);
        ja_t = 9'h020;
        jv_t = 1'b1;
        cyc(1);
        jv_t = 1'b0;
        checks++;
        if (busy !== 1'b1 || rd_address !== 9'h020) begin errors++;
            $display("FAIL djump_seek got %b/%h required 1/020",
                     busy, rd_address); end
        expect_run(9'h020, 3);
        consume(1000);
        checks++;
        if (goto_rises - r0 != 2) begin errors++;
            $display("FAIL djump_pulses got %0d required 2", goto_rises - r0); end
    endtask

    task automatic test_reset_stall();
        wait_stall(1000);
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        checks += 4;
        if (fetch_valid !== 1'b0 || ovf !== 1'b0) begin errors++;
            $display("FAIL rst2_flags got %b%b required 00", fetch_valid, ovf); end
        if (fetch_byte !== 8'h00 || fetch_addr !== 9'h000) begin errors++;
            $display("FAIL rst2_head got %h/%h required 00/000",
                     fetch_byte, fetch_addr); end
        if (rd_spi_clk !== 1'b0 || rd_hold_n !== 1'b1) begin errors++;
            $display("FAIL rst2_rd got %b%b required 01", rd_spi_clk, rd_hold_n); end
        if (rd_goto !== 1'b0) begin errors++;
            $display("FAIL rst2_goto got %b required 0", rd_goto); end
        cyc(1);
        checks++;
        if (busy !== 1'b1 || rd_goto !== 1'b1 || rd_address !== 9'h000) begin
            errors++;
            $display("FAIL rst2_boot got %b%b/%h required 11/000",
                     busy, rd_goto, rd_address); end
        expect_run(9'h000, 3);
        consume(1000);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_ovf();
        test_jump_wrap();
        test_jump_collide();
        test_double_jump();
        test_reset_stall();
        cyc(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout reached required finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/vslc_fetch_ctrl.md
VSLC_FETCH_CTRL -- requirements
Module: vslc_fetch_ctrl

Interface
REQ-001 SHALL have parameter SCK_DIV, default 2: clk cycles per rd_spi_clk half-period, legal values 1..255.
REQ-002 SHALL have parameter DEPTH, default 4: prefetch FIFO entries, power of two, legal values 2..16.
REQ-003 clk  in  1  system clock; all logic on posedge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 jump_valid  in  1  one-cycle request to restart fetch at jump_addr.
REQ-006 jump_addr  in  9  new fetch address.
REQ-007 fetch_valid  out  1  FIFO head valid.
REQ-008 fetch_byte  out  8  FIFO head data.
REQ-009 fetch_addr  out  9  EEPROM address of the FIFO head byte.
REQ-010 fetch_ready  in  1  consumer pops the head when fetch_valid=1 and fetch_ready=1.
REQ-011 rd_spi_clk  out  1  SPI clock to the EEPROM reader.
REQ-012 rd_goto  out  1  restart strobe to the reader; level, edge-detected by the reader.
REQ-013 rd_address  out  9  start address to the reader.
REQ-014 rd_hold_n  out  1  0 freezes the reader.
REQ-015 rd_ready  in  1  reader byte-complete level.
REQ-016 rd_byte  in  8  reader data byte.
REQ-017 busy  out  1  1 while in SEEK.
REQ-018 ovf  out  1  sticky: a byte arrived while the FIFO was full.

Function
REQ-019 The block SHALL implement FSM states SEEK, STREAM, STALL.
REQ-020 In SEEK and STREAM, rd_spi_clk SHALL toggle every SCK_DIV clk cycles, driven by an internal divider counter.
REQ-021 In STALL, rd_spi_clk SHALL hold its current level, the divider SHALL freeze, and rd_hold_n SHALL be 0; in SEEK and STREAM, rd_hold_n SHALL be 1.
REQ-022 On entering SEEK, the block SHALL load rd_address and the internal address counter nxt_addr with the target, flush the FIFO, and drive rd_goto=1.
REQ-023 rd_goto SHALL stay 1 for exactly 2 rd_spi_clk falling edges and then return to 0.
REQ-024 After that, the block SHALL go to STREAM with arm=0.
REQ-025 In STREAM, arm SHALL set when rd_ready is sampled 0; stale ready levels SHALL never be captured.
REQ-026 Capture SHALL occur on the cycle where rd_ready=1, the previous rd_ready=0, and arm=1.
REQ-027 On capture, the block SHALL push {rd_byte, nxt_addr} into the FIFO and increment nxt_addr modulo 512 (0x1FF wraps to 0x000).
REQ-028 The block SHALL enter STALL when the FIFO count reaches DEPTH, and return to STREAM the cycle after count drops below DEPTH.
REQ-029 A push and a pop in the same cycle SHALL leave the count unchanged.
REQ-030 A capture while the FIFO is full SHALL drop the byte and set ovf=1; ovf SHALL clear only on reset.
REQ-031 jump_valid SHALL be accepted in any state and enter SEEK with target jump_addr.
REQ-032 jump_valid SHALL win over a same-cycle pop or capture; both are discarded.
REQ-033 jump_valid during SEEK SHALL restart SEEK with the new target, including a full new rd_goto pulse.
REQ-034 fetch_valid SHALL equal (count != 0) and SHALL be 0 throughout SEEK.
REQ-035 fetch_byte and fetch_addr SHALL be registered FIFO head outputs, stable while fetch_valid=1 and fetch_ready=0.
REQ-036 busy SHALL be 1 exactly while the state is SEEK.

Reset
REQ-037 While rst_n=0 at a posedge, the block SHALL set: FIFO empty, fetch_valid=0, fetch_byte=0, fetch_addr=0, ovf=0, rd_spi_clk=0, divider=0, rd_hold_n=1, arm=0.
REQ-038 The first posedge with rst_n=1 SHALL enter SEEK with target 0x000 (rd_goto=1, rd_address=0, busy=1).
REQ-039 Reset asserted mid-SEEK, mid-STREAM or mid-STALL SHALL produce the same state as REQ-037, with no partial byte retained.

Verification
REQ-040 Reset release with an EEPROM model holding mem[i]=i^0x5A, SCK_DIV=2, fetch_ready=1 -> bytes 0x5A,0x5B,0x58 with fetch_addr 0,1,2, first fetch_valid within 40 rd_spi_clk periods.
REQ-041 fetch_ready=0, DEPTH=4 -> exactly 4 entries, STALL, rd_hold_n=0, rd_spi_clk frozen; raise fetch_ready -> the stream continues at address 4 with no gap or duplicate and ovf=0.
REQ-042 jump_valid with jump_addr=0x1FE mid-stream with the FIFO holding 3 bytes -> FIFO flushed the same cycle, one rd_goto pulse, next bytes at addresses 0x1FE, 0x1FF, 0x000.
REQ-043 jump_valid in the same cycle as a pop and a capture -> count=0, neither the popped nor the captured byte appears later, and the first byte comes from jump_addr.
REQ-044 Two jump_valid pulses 3 rd_spi_clk periods apart (0x010 then 0x020) -> the first byte delivered has fetch_addr=0x020 and nothing from 0x010 appears.
REQ-045 rst_n pulsed low for 1 cycle mid-STALL -> all REQ-037 values hold, then the stream restarts from address 0x000.
